// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
// Provides rx_state_e, clks_per_bit() and default clock/baud values.
package uart_rx_pkg;

    localparam int DEF_CLK_HZ = 50_000_000;
    localparam int DEF_BAUD   = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full is taken if a pop happens the same cycle.
// Ports: clk_i, rst_i, push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    // Head is forced to zero when empty so the output is clean after reset.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) level_d = level_q + (AW+1)'(1);
        if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO.
// Ports: clk_i, rst_i, rx_i, data_o/valid_o/ready_i, level_o, error pulses.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o
);

    localparam int DIV  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic            sync1_q, sync2_q, rx;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, full, empty, tick;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    assign rx   = sync2_q;
    assign tick = (cnt_q == DIV_M1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx) state_d = START;
            end
            START: begin
                // Mid-start check; counter restarts so DATA samples mid-bit.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rx, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d     = '0;
                    par_bad_d = (rx != ^shreg_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign pop        = valid_o && ready_i;
    assign overflow_d = push && full && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign valid_o     = !empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (shreg_q),
        .pop_i   (pop),
        .dout_o  (data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable UART receiver with a small output FIFO. It consumes the SoC's `uart_tx_pin` serial stream (8N1, 115200 baud by default) and presents received bytes on a valid/ready interface. Testbench tops instantiate it as a loop-back checker, and SoC variants use it as the RX front end. One clock domain; the only asynchronous input is the serial line.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate.
- `FIFO_DEPTH`, 8, byte entries; must be a power of two and at least 2.
- `clk_i  in  1  system clock`
- `rst_i  in  1  reset, asynchronous, active-high`
- `rx_i  in  1  serial line, idles high, asynchronous to clk_i`
- `data_o  out  8  FIFO head byte`
- `valid_o  out  1  FIFO non-empty`
- `ready_i  in  1  consumer accepts head`
- `level_o  out  $clog2(FIFO_DEPTH)+1  entries held`
- `frame_err_o  out  1  one-cycle pulse: stop bit sampled low`
- `parity_err_o  out  1  one-cycle pulse: parity mismatch (see Configuration)`
- `overflow_o  out  1  one-cycle pulse: byte dropped, FIFO full`

## Operation
- `rx_i` passes through a 2-FF synchronizer. Both FFs reset to 1.
- `DIV = CLK_HZ/BAUD`, using integer truncation (434 at the defaults). `HALF = DIV/2` (217).
- States:
  - IDLE: on a synced `rx` of 0 → START, with the counter cleared.
  - START: at count HALF-1, if `rx` is 1 (false start) → IDLE. Otherwise clear the counter → DATA.
  - DATA: sample every DIV cycles, LSB first, shifting into `shreg[7:0]`. After bit 7 → PARITY (macro on) or STOP.
  - PARITY: sample one bit and compare it against even parity of `shreg`.
  - STOP: sample after DIV cycles.
    - If `rx` is 1 and there is no parity error → push `shreg` and go to IDLE.
    - If `rx` is 0 → pulse `frame_err_o`, drop the byte, and go to BREAK.
    - On a parity error → pulse `parity_err_o`, drop the byte, and go to IDLE.
  - BREAK: wait for synced `rx` of 1, then → IDLE.
- FIFO:
  - Push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A push that is not accepted drops the byte and pulses `overflow_o`.
  - Pop happens when `valid_o && ready_i`.
  - Simultaneous push and pop leave `level_o` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- `data_o` is stable while `valid_o` is high and `ready_i` is low.
- Reset values:
  - `valid_o`, `level_o`, all error pulses and `data_o`: 0.
  - State: IDLE.
  - Pointers and counters: 0.
- Reset asserted mid-byte discards the partial byte and the FIFO contents. After reset is released, the receiver waits for a new falling edge.

## Timing
- Falling edge at `rx_i` to START entry: 2 cycles of synchronizer delay plus 1 cycle.
- Push occurs on the stop-bit sample cycle. `valid_o` rises the next cycle (first byte into an empty FIFO).
- Error pulses are registered, last exactly 1 cycle, and coincide with the cycle after the failing sample.
- Pop effect: `data_o` shows the next entry on the cycle after the handshake.
- Back-to-back frames with zero idle bits must be received; the stop-sample-to-IDLE path takes 1 cycle.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the frame is 8E1. The PARITY state is present, and `parity_err_o` is driven as described in Operation.
  - Undefined: the frame is 8N1. The PARITY state and its logic are compiled out, and `parity_err_o` is tied to 0. The port list is identical in both builds.

## Structure
- `uart_rx_pkg`:
  - `rx_state_e` enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `function clks_per_bit(clk_hz, baud)`.
  - `localparam` defaults for CLK_HZ and BAUD.
- Sub-module `sync_fifo`, parameterized by WIDTH=8 and DEPTH. It provides push/pop/full/empty/level and supports simultaneous push and pop when full. It is reusable by a future TX path.

## Test plan
- 0x55 sent at 115200 with `ready_i`=1 → `data_o`=0x55 with a one-cycle `valid_o`, no error pulses.
- 100 ns low glitch on `rx_i` → no byte, no error, state returns to IDLE.
- 0xA3 sent with the stop bit held low for 2 bit times → one `frame_err_o` pulse, FIFO empty. A following 0x3C is received correctly.
- 9 back-to-back bytes 0x01..0x09 with `ready_i`=0 → `level_o`=8 and a single `overflow_o` pulse on byte 9. Draining yields 0x01..0x08 in order.
- `rst_i` pulsed during bit 4 of 0xF0 → all outputs 0, no byte emitted. A following 0x0F is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 (wrong) → one `parity_err_o` pulse, nothing pushed. Sent with parity bit 1 → 0x07 received.
